// File: rtl/disp_data_sel_n.sv
// -----------------------------------------------------------------------------
// disp_data_sel_n
// N-channel display data selector. Picks one of N_CH sensor words and hands it
// to the display encoder. The channel advances on a debounced push-button press
// (manual mode) or on a fixed period (auto-scroll mode). Channels cleared in the
// ch_en mask are skipped. The output is held at zero and the selection at
// channel 0 until a post-reset startup hold has elapsed.
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   btn        in   raw push-button (asynchronous, active-high)
//   mode       in   0 = manual (button advances), 1 = auto-scroll
//   ch_en      in   per-channel enable mask, bit i enables channel i
//   data_in    in   packed channel words, channel i = data_in[i*DW +: DW]
//   dataout    out  selected channel word (registered)
//   ch_sel     out  index of the currently selected channel
//   dout_valid out  high once the startup hold has elapsed
//   ch_change  out  one-cycle pulse in the first cycle a new ch_sel is shown
// -----------------------------------------------------------------------------
module disp_data_sel_n #(
  parameter int  N_CH         = 4,
  parameter int  DW           = 16,
  parameter int  STARTUP_CYC  = 256,
  parameter int  DEBOUNCE_CYC = 50000,
  parameter int  AUTO_PERIOD  = 50000000,
  localparam int CW           = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  input  logic               mode,
  input  logic [N_CH-1:0]    ch_en,
  input  logic [N_CH*DW-1:0] data_in,
  output logic [DW-1:0]      dataout,
  output logic [CW-1:0]      ch_sel,
  output logic               dout_valid,
  output logic               ch_change
);

  // Counter widths sized to hold their terminal values.
  localparam int SW  = $clog2(STARTUP_CYC + 1);
  localparam int DBW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int AW  = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [SW-1:0]  SU_LAST   = SW'(STARTUP_CYC - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [AW-1:0]  AUTO_LAST = AW'(AUTO_PERIOD - 1);

  // Returns {found, index} of the first enabled channel after cur, scanning
  // cur+1, cur+2, ... modulo N_CH. The current channel itself is never a
  // candidate, so "only current enabled" and "none enabled" both report
  // found = 0. Scanning from the far end lets the nearest hit win.
  function automatic logic [CW:0] find_next(input logic [CW-1:0]   cur,
                                            input logic [N_CH-1:0] en);
    logic [CW:0]   res;
    logic [CW-1:0] idx;
    int            sum;
    res = {1'b0, cur};
    for (int k = N_CH - 1; k >= 1; k--) begin
      sum = int'(cur) + k;
      sum = (sum >= N_CH) ? (sum - N_CH) : sum;
      idx = CW'(sum);
      res = en[idx] ? {1'b1, idx} : res;
    end
    return res;
  endfunction

  // State registers
  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           btn_db_q, btn_db_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           btn_pulse_q, btn_pulse_d;
  logic [SW-1:0]  startup_cnt_q, startup_cnt_d;
  logic           dout_valid_q, dout_valid_d;
  logic           mode_prev_q, mode_prev_d;
  logic [AW-1:0]  auto_cnt_q, auto_cnt_d;
  logic [CW-1:0]  ch_sel_q, ch_sel_d;
  logic           ch_change_q, ch_change_d;
  logic [DW-1:0]  dataout_q, dataout_d;

  // Combinational helpers
  logic [DW-1:0]  ch_word_s [N_CH];
  logic [CW:0]    nxt_s;
  logic           mode_chg_s;
  logic           auto_tc_s;
  logic           advance_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_slice
    assign ch_word_s[g] = data_in[g*DW +: DW];
  end

  assign nxt_s      = find_next(ch_sel_q, ch_en);
  assign mode_chg_s = mode ^ mode_prev_q;
  // A mode change suppresses the terminal count so switching never advances.
  assign auto_tc_s  = mode & ~mode_chg_s & (auto_cnt_q == AUTO_LAST);
  // Button and terminal count are OR-ed, so a coincidence yields one advance.
  assign advance_s  = dout_valid_q & (btn_pulse_q | auto_tc_s);

  // Button synchroniser and debounce; pulse on accepted 0->1 level change.
  always_comb begin
    sync1_d     = btn;
    sync2_d     = sync1_q;
    btn_db_d    = btn_db_q;
    db_cnt_d    = db_cnt_q;
    btn_pulse_d = 1'b0;
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == DB_LAST) begin
        btn_db_d    = sync2_q;
        db_cnt_d    = '0;
        btn_pulse_d = sync2_q;
      end else begin
        db_cnt_d    = db_cnt_q + DBW'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Startup hold: count from reset release, then latch dout_valid high.
  always_comb begin
    startup_cnt_d = startup_cnt_q;
    dout_valid_d  = dout_valid_q;
    if (!dout_valid_q) begin
      startup_cnt_d = startup_cnt_q + SW'(1);
      dout_valid_d  = (startup_cnt_q == SU_LAST);
    end else begin
      startup_cnt_d = startup_cnt_q;
    end
  end

  // Auto-scroll timer: held at zero outside auto mode, restarted by presses.
  always_comb begin
    mode_prev_d = mode;
    if (!dout_valid_q || mode_chg_s || !mode || btn_pulse_q || auto_tc_s) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + AW'(1);
    end
  end

  // Channel selection and registered output word.
  always_comb begin
    ch_sel_d    = ch_sel_q;
    ch_change_d = 1'b0;
    if (!dout_valid_q) begin
      ch_sel_d = '0;
    end else if (advance_s && nxt_s[CW]) begin
      ch_sel_d    = nxt_s[CW-1:0];
      ch_change_d = 1'b1;
    end else begin
      ch_sel_d = ch_sel_q;
    end
    if (dout_valid_q) begin
      dataout_d = ch_word_s[ch_sel_q];
    end else begin
      dataout_d = '0;
    end
  end

  // State update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      db_cnt_q      <= '0;
      btn_pulse_q   <= 1'b0;
      startup_cnt_q <= '0;
      dout_valid_q  <= 1'b0;
      mode_prev_q   <= 1'b0;
      auto_cnt_q    <= '0;
      ch_sel_q      <= '0;
      ch_change_q   <= 1'b0;
      dataout_q     <= '0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      btn_db_q      <= btn_db_d;
      db_cnt_q      <= db_cnt_d;
      btn_pulse_q   <= btn_pulse_d;
      startup_cnt_q <= startup_cnt_d;
      dout_valid_q  <= dout_valid_d;
      mode_prev_q   <= mode_prev_d;
      auto_cnt_q    <= auto_cnt_d;
      ch_sel_q      <= ch_sel_d;
      ch_change_q   <= ch_change_d;
      dataout_q     <= dataout_d;
    end
  end

  assign dataout    = dataout_q;
  assign ch_sel     = ch_sel_q;
  assign dout_valid = dout_valid_q;
  assign ch_change  = ch_change_q;

endmodule
